// File: rtl/lzc_seq_pkg.sv
// Shared types and helpers for the sequential leading/trailing-zero counter.
package lzc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } lzc_state_e;

  typedef enum logic {
    LZC_TRAILING = 1'b0,
    LZC_LEADING  = 1'b1
  } lzc_mode_e;

  // Bits needed to index n items; never less than one so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lzc_seq_chunk.sv
// Combinational trailing-zero count of a single CHUNK-bit slice.
module lzc_chunk
  import lzc_seq_pkg::*;
#(
  parameter  int CHUNK = 8,
  localparam int TZ_W  = idx_width(CHUNK)
) (
  input  logic [CHUNK-1:0] chunk_i,
  output logic             nz_o,
  output logic [TZ_W-1:0]  tz_o
);

  assign nz_o = |chunk_i;

  // Priority encode the lowest set bit; scanning downward lets the last hit win.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    tz_o = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk_i[i]) tz_o = TZ_W'(i);
    end
  end

endmodule

// File: rtl/lzc_seq.sv
// Sequential leading/trailing-zero counter, CHUNK bits per scan cycle.
// Build option: define LZC_SEQ_EARLY_EXIT_EN to stop scanning at the first
// nonzero chunk; leave it undefined for constant-time scanning.
module lzc_seq
  import lzc_seq_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int CHUNK     = 8,
  parameter int CNT_WIDTH = idx_width(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     in_i,
  input  logic                 mode_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam int TZ_W   = idx_width(CHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  lzc_state_e           state_q, state_d;
  logic [WIDTH-1:0]     op_q, op_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 empty_q, empty_d;
`ifndef LZC_SEQ_EARLY_EXIT_EN
  logic                 hit_q, hit_d;
`endif

  logic [WIDTH-1:0]     in_rev;
  logic [CHUNK-1:0]     cur_chunk;
  logic                 chunk_nz;
  logic [TZ_W-1:0]      chunk_tz;
  logic [CNT_WIDTH-1:0] hit_cnt;

  // Leading-zero count is a trailing-zero count of the mirrored operand.
  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign in_rev[g] = in_i[WIDTH-1-g];
  end

  assign cur_chunk = op_q[idx_q*CHUNK +: CHUNK];

  lzc_chunk #(.CHUNK(CHUNK)) u_chunk (
    .chunk_i (cur_chunk),
    .nz_o    (chunk_nz),
    .tz_o    (chunk_tz)
  );

  // CHUNK is a power of two, so idx*CHUNK + tz is simply {idx, tz}.
  assign hit_cnt = {idx_q, chunk_tz};

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign cnt_o   = cnt_q;
  assign empty_o = empty_q;

  // Next-state logic for FSM, operand, scan index and result.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    empty_d = empty_q;
`ifndef LZC_SEQ_EARLY_EXIT_EN
    hit_d   = hit_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          op_d    = (lzc_mode_e'(mode_i) == LZC_LEADING) ? in_rev : in_i;
          idx_d   = '0;
          cnt_d   = '0;
          empty_d = 1'b0;
`ifndef LZC_SEQ_EARLY_EXIT_EN
          hit_d   = 1'b0;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
`ifdef LZC_SEQ_EARLY_EXIT_EN
        if (chunk_nz) begin
          cnt_d   = hit_cnt;
          empty_d = 1'b0;
          state_d = DONE;
        end else if (idx_q == LAST_IDX) begin
          cnt_d   = '0;
          empty_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`else
        // Only the first hit is recorded; every operand walks all chunks.
        if (chunk_nz && !hit_q) begin
          cnt_d = hit_cnt;
          hit_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          if (!hit_q && !chunk_nz) begin
            cnt_d   = '0;
            empty_d = 1'b1;
          end
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b0;
`ifndef LZC_SEQ_EARLY_EXIT_EN
      hit_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
`ifndef LZC_SEQ_EARLY_EXIT_EN
      hit_q   <= hit_d;
`endif
    end
  end

endmodule

// File: tb/tb_lzc_seq.sv
// Directed, table-driven bench for lzc_seq (WIDTH=64, CHUNK=8).
module tb_lzc_seq;

  localparam int WIDTH = 64;
  localparam int CHUNK = 8;
  localparam int CNT_W = 6;
  localparam int MAX_WAIT = 40;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] in_i;
  logic             mode_i;
  logic             valid_o;
  logic             ready_i;
  logic [CNT_W-1:0] cnt_o;
  logic             empty_o;

  int errors = 0;
  int checks = 0;

  lzc_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .in_i    (in_i),
    .mode_i  (mode_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .cnt_o   (cnt_o),
    .empty_o (empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] in;
    logic        mode;
    int          cnt;
    logic        empty;
    int          lat_early;
    int          lat_ct;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accept one request, wait for valid_o, return result and latency in cycles.
  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic run_op(input logic [63:0] din, input logic m,
                        output int cnt, output logic emp, output int lat);
    int edges;
    check("ready_before_accept", ready_o, 1);
    valid_i = 1'b1;
    in_i    = din;
    mode_i  = m;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    in_i    = '1;
    mode_i  = ~m;
    edges   = 0;
    while (!valid_o && edges < MAX_WAIT) begin
      check("ready_low_busy", ready_o, 0);
      @(posedge clk_i); #1;
      edges++;
    end
    if (!valid_o) begin
      errors++;
      $display("FAIL timeout: valid_o never rose after %0d cycles", edges);
    end
    cnt = int'(cnt_o);
    emp = empty_o;
    lat = edges + 1;
  endtask

  task automatic retire();
    ready_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    int   cnt;
    logic emp;
    int   lat;
    int   exp_lat;

    vecs[0]  = '{64'h0000_0000_0000_0100, 1'b0,  8, 1'b0, 3, 9};
    vecs[1]  = '{64'h0000_8000_0000_0000, 1'b1, 16, 1'b0, 4, 9};
    vecs[2]  = '{64'h0000_0000_0000_0001, 1'b1, 63, 1'b0, 9, 9};
    vecs[3]  = '{64'h8000_0000_0000_0000, 1'b0, 63, 1'b0, 9, 9};
    vecs[4]  = '{64'h0000_0000_0000_0000, 1'b0,  0, 1'b1, 9, 9};
    vecs[5]  = '{64'h0000_0000_0000_0000, 1'b1,  0, 1'b1, 9, 9};
    vecs[6]  = '{64'h0000_0000_0000_0001, 1'b0,  0, 1'b0, 2, 9};
    vecs[7]  = '{64'h8000_0000_0000_0000, 1'b1,  0, 1'b0, 2, 9};
    vecs[8]  = '{64'hF0F0_0000_0000_0000, 1'b0, 52, 1'b0, 8, 9};
    vecs[9]  = '{64'h0000_0000_0001_0000, 1'b1, 47, 1'b0, 7, 9};
    vecs[10] = '{64'h0000_0000_0000_0006, 1'b0,  1, 1'b0, 2, 9};
    vecs[11] = '{64'h0000_0040_0000_0000, 1'b0, 38, 1'b0, 6, 9};

    rst_i   = 1'b1;
    valid_i = 1'b0;
    in_i    = '0;
    mode_i  = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_valid_o", valid_o, 0);
    check("reset_ready_o", ready_o, 1);
    check("reset_cnt_o",   cnt_o,   0);
    check("reset_empty_o", empty_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].in, vecs[i].mode, cnt, emp, lat);
`ifdef LZC_SEQ_EARLY_EXIT_EN
      exp_lat = vecs[i].lat_early;
`else
      exp_lat = vecs[i].lat_ct;
`endif
      check($sformatf("vec%0d_cnt", i),     cnt, vecs[i].cnt);
      check($sformatf("vec%0d_empty", i),   emp, vecs[i].empty);
      check($sformatf("vec%0d_latency", i), lat, exp_lat);
      retire();
      check($sformatf("vec%0d_idle_after", i), ready_o, 1);
    end

    // Backpressure: hold the result for 5 cycles while new requests are offered.
    ready_i = 1'b0;
    run_op(64'h0000_0000_0000_0100, 1'b0, cnt, emp, lat);
    check("bp_cnt", cnt, 8);
    for (int c = 0; c < 5; c++) begin
      valid_i = c[0] ? 1'b0 : 1'b1;
      in_i    = 64'h0000_0000_0000_FFFF;
      mode_i  = 1'b1;
      @(posedge clk_i); #1;
      check("bp_valid_hold", valid_o, 1);
      check("bp_cnt_hold",   cnt_o,   8);
      check("bp_empty_hold", empty_o, 0);
      check("bp_ready_low",  ready_o, 0);
    end
    valid_i = 1'b0;
    retire();
    check("bp_release_ready", ready_o, 1);
    check("bp_release_valid", valid_o, 0);
    run_op(64'h0000_0000_0000_8000, 1'b0, cnt, emp, lat);
    check("bp_next_cnt",   cnt, 15);
    check("bp_next_empty", emp, 0);
    retire();

    // Reset in the middle of an all-zero scan.
    valid_i = 1'b1;
    in_i    = '0;
    mode_i  = 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_ready", ready_o, 1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_i); #1;
      check("rst_no_stale_valid", valid_o, 0);
      check("rst_idle_ready",     ready_o, 1);
    end
    run_op(64'h0000_0000_0000_0010, 1'b0, cnt, emp, lat);
`ifdef LZC_SEQ_EARLY_EXIT_EN
    exp_lat = 2;
`else
    exp_lat = 9;
`endif
    check("rst_next_cnt",     cnt, 4);
    check("rst_next_empty",   emp, 0);
    check("rst_next_latency", lat, exp_lat);
    retire();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
